com_uart_rx_fifo: RTL and testbench

COM_UART_RX_FIFO -- requirements
Module: com_uart_rx_fifo

---
 rtl/com_uart_pkg.sv | 13 +
 rtl/com_sync_2ff.sv | 27 ++
 rtl/com_uart_rx_fifo.sv | 117 +++++++++++
 tb/tb_com_uart_rx_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/com_uart_pkg.sv
// Shared constants for the UART receive path: default FIFO geometry and entry layout.
// An entry is {parity_error, data}, so it is one bit wider than a character.
package com_uart_pkg;

    localparam int unsigned DefaultDepth  = 16;
    localparam int unsigned DefaultDataW  = 8;
    localparam int unsigned DefaultEntryW = DefaultDataW + 1;

    function automatic int unsigned entry_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/com_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// The reset value is a parameter so that idle-high inputs can reset high.
module com_sync_2ff #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= ResetVal;
            s2_q <= ResetVal;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/com_uart_rx_fifo.sv
// Receive FIFO for the UART: one push per rising edge of the receiver's completion level,
// show-ahead read port, sticky overflow when a character arrives while full.
module com_uart_rx_fifo
    import com_uart_pkg::*;
#(
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_write_en,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_valid_packet,
    input  logic                     rd_en,
    input  logic                     clear_overflow,
    output logic [DATA_W-1:0]        data_out,
    output logic                     parity_err_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = entry_width(DATA_W);

    logic          s2;
    logic          s2_d_q;
    logic          push;
    logic          pop_ok;
    logic          wr_ok;
    logic          ovf_set;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    // Reset high so a receiver idling high after reset does not look like a new character.
    com_sync_2ff #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_write_en),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_d_q <= 1'b1;
        end else begin
            s2_d_q <= s2;
        end
    end

    assign push    = s2 & ~s2_d_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign pop_ok  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_ok   = push & (~full | pop_ok);
    assign ovf_set = push & full & ~pop_ok;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_ok && !pop_ok) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!wr_ok && pop_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= {~rx_valid_packet, rx_data};
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign data_out       = empty ? '0 : head[DATA_W-1:0];
    assign parity_err_out = ~empty & head[DATA_W];
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_com_uart_rx_fifo.sv
// Directed bench for com_uart_rx_fifo with a queue scoreboard of expected entries.
module tb_com_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_write_en;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid_packet;
    logic              rd_en;
    logic              clear_overflow;
    logic [DATA_W-1:0] data_out;
    logic              parity_err_out;
    logic              empty;
    logic              full;
    logic [4:0]        count;
    logic              overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [8:0]  sb [$];
    int unsigned m_cnt = 0;
    logic        m_ovf = 1'b0;

    com_uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_write_en     (rx_write_en),
        .rx_data         (rx_data),
        .rx_valid_packet (rx_valid_packet),
        .rd_en           (rd_en),
        .clear_overflow  (clear_overflow),
        .data_out        (data_out),
        .parity_err_out  (parity_err_out),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), m_cnt);
        check({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        check({tag, ".full"}, 32'(full), 32'(m_cnt == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One receiver character: low long enough to be seen, then high. Optional pop and
    // clear_overflow are asserted exactly in the push cycle (two edges after the rise).
    task automatic pulse(input logic [7:0] d, input logic v, input logic pop, input logic clr);
        logic       pop_ok;
        logic       drop;
        logic [8:0] exp;
        @(posedge clk);
        #1 rx_write_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_data = d;
        rx_valid_packet = v;
        rx_write_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rd_en = pop;
        clear_overflow = clr;
        check("push_latency.count", 32'(count), m_cnt);
        pop_ok = pop && (m_cnt > 0);
        drop   = (m_cnt == DEPTH) && !pop_ok;
        if (pop_ok) begin
            exp = sb.pop_front();
            check("pop_in_push.data", 32'(data_out), 32'(exp[7:0]));
            check("pop_in_push.parity", 32'(parity_err_out), 32'(exp[8]));
        end
        if (drop) begin
            m_ovf = 1'b1;
        end else begin
            sb.push_back({~v, d});
            if (clr) m_ovf = 1'b0;
        end
        m_cnt = sb.size();
        @(posedge clk);
        #1 rd_en = 1'b0;
        clear_overflow = 1'b0;
        check_state("push");
    endtask

    task automatic pop_one(input string tag);
        logic [8:0] exp;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, ".data"}, 32'(data_out), 32'(exp[7:0]));
            check({tag, ".parity"}, 32'(parity_err_out), 32'(exp[8]));
        end else begin
            check({tag, ".data_empty"}, 32'(data_out), 32'h0);
            check({tag, ".parity_empty"}, 32'(parity_err_out), 32'h0);
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        m_cnt = sb.size();
        check_state(tag);
    endtask

    task automatic clear_ovf();
        clear_overflow = 1'b1;
        @(posedge clk);
        #1 clear_overflow = 1'b0;
        m_ovf = 1'b0;
        check("clear_ovf.overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        rst             = 1'b1;
        rx_write_en     = 1'b1;
        rx_data         = '0;
        rx_valid_packet = 1'b1;
        rd_en           = 1'b0;
        clear_overflow  = 1'b0;

        #12;
        check_state("reset");
        check("reset.data_out", 32'(data_out), 32'h0);
        check("reset.parity", 32'(parity_err_out), 32'h0);

        // Receiver idles high through reset release: nothing may be pushed.
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_state("idle_high");
        check("idle_high.data_out", 32'(data_out), 32'h0);

        // Single character, then pop back to empty, then a pop on empty is ignored.
        pulse(8'hA5, 1'b1, 1'b0, 1'b0);
        pop_one("a5");
        pop_one("rd_empty");

        // 17 characters into a 16-deep FIFO: the last is dropped and overflow sticks.
        for (int i = 0; i <= 16; i++) begin
            pulse(8'(i), 1'b1, 1'b0, 1'b0);
        end
        clear_ovf();

        // Push with simultaneous pop while full: both succeed, no overflow.
        pulse(8'h55, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            pop_one("drain1");
        end

        // Bad parity entry, fill to full, then overflow while clear_overflow is asserted.
        pulse(8'h3C, 1'b0, 1'b0, 1'b0);
        check("bad_parity.data", 32'(data_out), 32'h3C);
        check("bad_parity.flag", 32'(parity_err_out), 32'h1);
        for (int i = 1; i < 16; i++) begin
            pulse(8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
        end
        pulse(8'hEE, 1'b1, 1'b0, 1'b1);
        clear_ovf();
        for (int i = 0; i < 16; i++) begin
            pop_one("drain2");
        end

        // Asynchronous reset mid-operation with five entries held.
        for (int i = 0; i < 5; i++) begin
            pulse(8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        end
        #3 rst = 1'b1;
        #1;
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        check_state("async_rst");
        check("async_rst.data_out", 32'(data_out), 32'h0);
        check("async_rst.parity", 32'(parity_err_out), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_state("post_rst_idle");
        pulse(8'h77, 1'b1, 1'b0, 1'b0);
        pop_one("post_rst");
        pop_one("post_rst_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
